// File: rtl/image_frame_buffer.sv
// image_frame_buffer: double-buffered per-channel pixel store, 2-cycle read pipeline, bank swap at a safe point.
// Optional macro FB_CLEAR_EN adds clear_req/clear_color and a CLEAR state that fills the back bank.
module image_frame_buffer #(
  parameter int PIXEL_W  = 24,
  parameter int CHANNELS = 3,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [X_W-1:0]      wr_x,
  input  logic [Y_W-1:0]      wr_y,
  input  logic [PIXEL_W-1:0]  wr_data,
  input  logic [CHANNELS-1:0] wr_chan_en,
  input  logic                rd_req,
  input  logic [X_W-1:0]      rd_x,
  input  logic [Y_W-1:0]      rd_y,
  output logic                rd_valid,
  output logic [PIXEL_W-1:0]  rd_data,
  output logic                rd_oob,
`ifdef FB_CLEAR_EN
  input  logic                clear_req,
  input  logic [PIXEL_W-1:0]  clear_color,
`endif
  input  logic                swap_req,
  output logic                swap_done,
  output logic                front_bank,
  output logic [CNT_W-1:0]    drop_count
);

  localparam int CH_W  = PIXEL_W / CHANNELS;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = 2 * NPIX;
  localparam int A_W   = $clog2(DEPTH);
  localparam logic [A_W-1:0] BANK_OFS = A_W'(NPIX);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, SWAP, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SWAP} state_t;
`endif

  state_t state, state_nxt;
  logic   started;
  logic   wr_acc, wr_inb, rd_inb;
  logic [A_W-1:0] front_base, back_base, wr_addr, rd_addr, mem_waddr;
  logic [CHANNELS-1:0] mem_we;
  logic [PIXEL_W-1:0]  mem_wdata, mem_q;
  logic           s1_valid, s1_oob;
  logic [A_W-1:0] s1_addr;
  logic           zero_q;

`ifdef FB_CLEAR_EN
  logic [A_W-1:0]     clr_cnt;
  logic [PIXEL_W-1:0] clr_color;
  logic               swap_pend;
`endif

  // started masks wr_ready during the first cycle after reset is released
  assign wr_ready  = started && (state == IDLE);
  assign swap_done = (state == SWAP);
  assign wr_acc    = wr_valid && wr_ready;
  assign wr_inb    = (32'(wr_x) < IMG_W) && (32'(wr_y) < IMG_H);
  assign rd_inb    = (32'(rd_x) < IMG_W) && (32'(rd_y) < IMG_H);

  assign front_base = front_bank ? BANK_OFS : '0;
  assign back_base  = front_bank ? '0 : BANK_OFS;
  assign wr_addr    = back_base + A_W'(wr_y) * A_W'(IMG_W) + A_W'(wr_x);
  assign rd_addr    = front_base + A_W'(rd_y) * A_W'(IMG_W) + A_W'(rd_x);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef FB_CLEAR_EN
        if (clear_req)     state_nxt = CLEAR;
        else if (swap_req) state_nxt = SWAP;
`else
        if (swap_req)      state_nxt = SWAP;
`endif
      end
      SWAP: state_nxt = IDLE;
`ifdef FB_CLEAR_EN
      CLEAR: begin
        if (clr_cnt == A_W'(NPIX - 1))
          state_nxt = (swap_pend || swap_req) ? SWAP : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Bank toggles on entry to SWAP so reads issued during SWAP already see the new front
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      started    <= 1'b0;
      front_bank <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (state_nxt == SWAP && state != SWAP)
        front_bank <= ~front_bank;
      if (wr_acc && !wr_inb && drop_count != '1)
        drop_count <= drop_count + CNT_W'(1);
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt   <= '0;
      clr_color <= '0;
      swap_pend <= 1'b0;
    end else if (state == IDLE && state_nxt == CLEAR) begin
      clr_cnt   <= '0;
      clr_color <= clear_color;
      swap_pend <= swap_req;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + A_W'(1);
      if (swap_req)
        swap_pend <= 1'b1;
    end
  end
`endif

  always_comb begin
    mem_we    = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (wr_acc && wr_inb)
      mem_we = wr_chan_en;
`ifdef FB_CLEAR_EN
    if (state == CLEAR) begin
      mem_we    = '1;
      mem_waddr = back_base + clr_cnt;
      mem_wdata = clr_color;
    end
`endif
  end

  // One RAM per channel; the read register only loads for in-range reads so rd_data holds otherwise
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [CH_W-1:0] mem [DEPTH];
    logic [CH_W-1:0] q;
    always_ff @(posedge clk) begin
      if (mem_we[k])
        mem[mem_waddr] <= mem_wdata[k*CH_W +: CH_W];
      if (s1_valid && !s1_oob)
        q <= mem[s1_addr];
    end
    assign mem_q[k*CH_W +: CH_W] = q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_addr  <= '0;
      rd_valid <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      s1_valid <= rd_req;
      s1_oob   <= !rd_inb;
      s1_addr  <= rd_inb ? rd_addr : '0;
      rd_valid <= s1_valid;
      if (s1_valid)
        zero_q <= s1_oob;
    end
  end

  assign rd_data = zero_q ? '0 : mem_q;
  assign rd_oob  = rd_valid && zero_q;

endmodule

// File: tb/tb_image_frame_buffer.sv
// tb_image_frame_buffer: table-driven write/swap/read vectors plus hand sequences for swap timing,
// writes held across SWAP, reset mid-operation and (with FB_CLEAR_EN) the back-bank clear.
module tb_image_frame_buffer;

  localparam int OP_W = 0;
  localparam int OP_S = 1;
  localparam int OP_R = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [23:0] wr_data;
  logic [2:0]  wr_chan_en;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        rd_oob;
  logic        swap_req;
  logic        swap_done;
  logic        front_bank;
  logic [15:0] drop_count;
`ifdef FB_CLEAR_EN
  logic        clear_req;
  logic [23:0] clear_color;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          op;
    int          x;
    int          y;
    logic [23:0] data;
    logic [2:0]  en;
    logic [23:0] exp_data;
    logic        exp_oob;
    logic        exp_front;
  } vec_t;

  vec_t vecs[22];

  image_frame_buffer dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_chan_en(wr_chan_en),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_oob(rd_oob),
`ifdef FB_CLEAR_EN
    .clear_req(clear_req), .clear_color(clear_color),
`endif
    .swap_req(swap_req), .swap_done(swap_done), .front_bank(front_bank),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doWrite(input int x, input int y, input logic [23:0] d, input logic [2:0] en);
    int n;
    wr_valid   = 1'b1;
    wr_x       = 8'(x);
    wr_y       = 7'(y);
    wr_data    = d;
    wr_chan_en = en;
    n = 0;
    while (!wr_ready && n < 8) begin
      tick();
      n++;
    end
    if (!wr_ready) checkOutput("wr_ready timeout", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic doSwap(input logic exp_front);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checkOutput("swap_done pulse", 32'(swap_done), 32'd1);
    checkOutput("front_bank after swap", 32'(front_bank), 32'(exp_front));
    tick();
    checkOutput("swap_done one cycle", 32'(swap_done), 32'd0);
  endtask

  task automatic doRead(input int x, input int y, input logic [23:0] exp_d, input logic exp_oob);
    rd_req = 1'b1;
    rd_x   = 8'(x);
    rd_y   = 7'(y);
    tick();
    rd_req = 1'b0;
    checkOutput("rd_valid at +1", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("rd_valid at +2", 32'(rd_valid), 32'd1);
    checkOutput("rd_data", 32'(rd_data), 32'(exp_d));
    checkOutput("rd_oob", 32'(rd_oob), 32'(exp_oob));
    tick();
    checkOutput("rd_valid at +3", 32'(rd_valid), 32'd0);
    checkOutput("rd_oob idle", 32'(rd_oob), 32'd0);
    checkOutput("rd_data hold", 32'(rd_data), 32'(exp_d));
  endtask

  task automatic applyStimulus(input vec_t v);
    case (v.op)
      OP_W:    doWrite(v.x, v.y, v.data, v.en);
      OP_S:    doSwap(v.exp_front);
      default: doRead(v.x, v.y, v.exp_data, v.exp_oob);
    endcase
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("reset front_bank", 32'(front_bank), 32'd0);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset rd_data", 32'(rd_data), 32'd0);
    checkOutput("reset swap_done", 32'(swap_done), 32'd0);
    checkOutput("reset drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;
    checkOutput("reset-exit wr_ready", 32'(wr_ready), 32'd0);
    tick();
    checkOutput("idle wr_ready", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    // op, x, y, wr data, en, expected rd data, expected oob, expected front after swap
    vecs[0]  = '{OP_W,   3,   2, 24'hA1B2C3, 3'b111, 24'h0,      1'b0, 1'b0};
    vecs[1]  = '{OP_W,   0,   0, 24'h5A5A5A, 3'b111, 24'h0,      1'b0, 1'b0};
    vecs[2]  = '{OP_S,   0,   0, 24'h0,      3'b000, 24'h0,      1'b0, 1'b1};
    vecs[3]  = '{OP_R,   3,   2, 24'h0,      3'b000, 24'hA1B2C3, 1'b0, 1'b0};
    vecs[4]  = '{OP_S,   0,   0, 24'h0,      3'b000, 24'h0,      1'b0, 1'b0};
    vecs[5]  = '{OP_W,   3,   2, 24'hFFFFFF, 3'b010, 24'h0,      1'b0, 1'b0};
    vecs[6]  = '{OP_S,   0,   0, 24'h0,      3'b000, 24'h0,      1'b0, 1'b1};
    vecs[7]  = '{OP_R,   3,   2, 24'h0,      3'b000, 24'hA1FFC3, 1'b0, 1'b0};
    vecs[8]  = '{OP_W,   0,   1, 24'h123456, 3'b111, 24'h0,      1'b0, 1'b0};
    vecs[9]  = '{OP_W,   0,   0, 24'h0ABCDE, 3'b111, 24'h0,      1'b0, 1'b0};
    vecs[10] = '{OP_W, 159, 119, 24'h7E7E7E, 3'b111, 24'h0,      1'b0, 1'b0};
    vecs[11] = '{OP_W,   0,   1, 24'h000000, 3'b000, 24'h0,      1'b0, 1'b0};
    vecs[12] = '{OP_W, 160,   0, 24'hFFFFFF, 3'b111, 24'h0,      1'b0, 1'b0};
    vecs[13] = '{OP_W,   0, 120, 24'h999999, 3'b111, 24'h0,      1'b0, 1'b0};
    vecs[14] = '{OP_R,   0,   0, 24'h0,      3'b000, 24'h5A5A5A, 1'b0, 1'b0};
    vecs[15] = '{OP_S,   0,   0, 24'h0,      3'b000, 24'h0,      1'b0, 1'b0};
    vecs[16] = '{OP_R,   0,   1, 24'h0,      3'b000, 24'h123456, 1'b0, 1'b0};
    vecs[17] = '{OP_R,   0,   0, 24'h0,      3'b000, 24'h0ABCDE, 1'b0, 1'b0};
    vecs[18] = '{OP_R, 159, 119, 24'h0,      3'b000, 24'h7E7E7E, 1'b0, 1'b0};
    vecs[19] = '{OP_R, 200,   5, 24'h0,      3'b000, 24'h000000, 1'b1, 1'b0};
    vecs[20] = '{OP_R,   3, 120, 24'h0,      3'b000, 24'h000000, 1'b1, 1'b0};
    vecs[21] = '{OP_R, 160,   0, 24'h0,      3'b000, 24'h000000, 1'b1, 1'b0};

    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; wr_chan_en = '0;
    rd_req = 1'b0; rd_x = '0; rd_y = '0; swap_req = 1'b0;
`ifdef FB_CLEAR_EN
    clear_req = 1'b0; clear_color = '0;
`endif

    doReset();

    for (int i = 0; i < 22; i++) applyStimulus(vecs[i]);
    checkOutput("drop_count after two oob writes", 32'(drop_count), 32'd2);

    // read issued with swap_req returns old front; the next read sees the new front
    doWrite(10, 10, 24'h222222, 3'b111);
    doSwap(1'b1);
    doWrite(10, 10, 24'h111111, 3'b111);
    doSwap(1'b0);
    rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd10; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checkOutput("swap_done with read", 32'(swap_done), 32'd1);
    tick();
    rd_req = 1'b0;
    checkOutput("read before swap valid", 32'(rd_valid), 32'd1);
    checkOutput("read before swap data", 32'(rd_data), 32'h111111);
    tick();
    checkOutput("read after swap valid", 32'(rd_valid), 32'd1);
    checkOutput("read after swap data", 32'(rd_data), 32'h222222);
    tick();

    // write held valid across SWAP lands in the new back bank
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_valid = 1'b1; wr_x = 8'd20; wr_y = 7'd20; wr_data = 24'h333333; wr_chan_en = 3'b111;
    checkOutput("wr_ready low in SWAP", 32'(wr_ready), 32'd0);
    tick();
    checkOutput("wr_ready back after SWAP", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    doSwap(1'b1);
    doRead(20, 20, 24'h333333, 1'b0);

    // reset in the middle of a swap with a read in flight
    rd_req = 1'b1; rd_x = 8'd20; rd_y = 7'd20; swap_req = 1'b1;
    tick();
    rd_req = 1'b0; swap_req = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("mid reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("mid reset swap_done", 32'(swap_done), 32'd0);
    checkOutput("mid reset front_bank", 32'(front_bank), 32'd0);
    checkOutput("mid reset drop_count", 32'(drop_count), 32'd0);
    tick();
    checkOutput("mid reset rd_valid late", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    tick();

`ifdef FB_CLEAR_EN
    begin
      int n;
      int ready_seen;
      clear_req = 1'b1; clear_color = 24'h0000FF; swap_req = 1'b1;
      tick();
      clear_req = 1'b0; swap_req = 1'b0;
      n = 0;
      ready_seen = 0;
      while (!swap_done && n < 20000) begin
        if (wr_ready) ready_seen++;
        tick();
        n++;
      end
      checkOutput("clear length", 32'(n), 32'd19200);
      checkOutput("wr_ready during clear", 32'(ready_seen), 32'd0);
      checkOutput("front after clear swap", 32'(front_bank), 32'd1);
      tick();
      doRead(5, 5, 24'h0000FF, 1'b0);
      doRead(159, 119, 24'h0000FF, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
